// File: rtl/mfp_timer_pkg.sv
// Shared MFP timer definitions: mode encodings, mode decode and the prescaler divisor table.
package mfp_timer_pkg;

  typedef enum logic [1:0] {
    MODE_STOPPED = 2'd0,
    MODE_DELAY   = 2'd1,
    MODE_EVENT   = 2'd2,
    MODE_PULSE   = 2'd3
  } timer_mode_e;

  localparam logic [3:0] MODE_CODE_STOP  = 4'b0000;
  localparam logic [3:0] MODE_CODE_EVENT = 4'b1000;

  // Widest divisor is 200, so an 8-bit divider counter is enough.
  localparam int PRESC_W = 8;

  function automatic timer_mode_e decode_mode(input logic [3:0] code);
    timer_mode_e kind;
    if (code == MODE_CODE_STOP) begin
      kind = MODE_STOPPED;
    end else if (code == MODE_CODE_EVENT) begin
      kind = MODE_EVENT;
    end else if (code[3]) begin
      kind = MODE_PULSE;
    end else begin
      kind = MODE_DELAY;
    end
    return kind;
  endfunction

  function automatic logic [PRESC_W-1:0] presc_divisor(input logic [2:0] sel);
    logic [PRESC_W-1:0] div;
    case (sel)
      3'd1:    div = 8'd4;
      3'd2:    div = 8'd10;
      3'd3:    div = 8'd16;
      3'd4:    div = 8'd50;
      3'd5:    div = 8'd64;
      3'd6:    div = 8'd100;
      3'd7:    div = 8'd200;
      default: div = 8'd0;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/mfp_prescaler.sv
// XCLK synchroniser and programmable divider; emits one tick per divider wrap.
module mfp_prescaler
  import mfp_timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       xclk_i,
  input  logic       clear,
  input  logic [2:0] select,
  output logic       tick
);

  logic               xclk_s1_q, xclk_s1_d;
  logic               xclk_s2_q, xclk_s2_d;
  logic               xclk_s3_q, xclk_s3_d;
  logic [PRESC_W-1:0] div_cnt_q, div_cnt_d;
  logic [PRESC_W-1:0] divisor;
  logic               xclk_rise;
  logic               at_wrap;

  always_comb begin
    xclk_s1_d = xclk_i;
    xclk_s2_d = xclk_s1_q;
    xclk_s3_d = xclk_s2_q;
    divisor   = presc_divisor(select);
    xclk_rise = xclk_s2_q & ~xclk_s3_q;
    at_wrap   = (div_cnt_q == (divisor - PRESC_W'(1)));
    div_cnt_d = div_cnt_q;
    tick      = 1'b0;
    // A zero divisor (select 0) means no prescaled clock, so the divider idles.
    if (clear || (divisor == '0)) begin
      div_cnt_d = '0;
    end else if (xclk_rise) begin
      if (at_wrap) begin
        div_cnt_d = '0;
        tick      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xclk_s1_q <= 1'b0;
      xclk_s2_q <= 1'b0;
      xclk_s3_q <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      xclk_s1_q <= xclk_s1_d;
      xclk_s2_q <= xclk_s2_d;
      xclk_s3_q <= xclk_s3_d;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/mfp_timer_n.sv
// MFP-style timer: delay, event and pulse-width modes with reloadable down-counter.
// Optional one-shot behaviour is enabled with the MFP_TIMER_ONESHOT_EN macro.
module mfp_timer_n
  import mfp_timer_pkg::*;
#(
  parameter int   CNT_W     = 8,
  parameter logic PULSE_POL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             XCLK_I,
  input  logic             T_I,
  input  logic             DS,
  input  logic             DAT_WE,
  input  logic [CNT_W-1:0] DAT_I,
  output logic [CNT_W-1:0] DAT_O,
  input  logic             CTRL_WE,
  input  logic [5:0]       CTRL_I,
  output logic [4:0]       CTRL_O,
  output logic             T_O,
  output logic             T_O_PULSE,
  output logic             PULSE_MODE,
  output logic [CNT_W-1:0] SET_DATA_OUT
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dat_o_q, dat_o_d;
  logic [3:0]       mode_q, mode_d;
  logic             t_o_q, t_o_d;
  logic             t_o_pulse_q, t_o_pulse_d;
  logic             ti_s1_q, ti_s1_d;
  logic             ti_s2_q, ti_s2_d;
  logic             ti_s3_q, ti_s3_d;
  logic             oneshot;

  timer_mode_e mode_kind;
  logic        presc_clear;
  logic        presc_tick;
  logic        ti_rise;
  logic        tick;
  logic        timeout;

`ifdef MFP_TIMER_ONESHOT_EN
  logic oneshot_q, oneshot_d;

  always_comb begin
    oneshot_d = oneshot_q;
    if (CTRL_WE) begin
      oneshot_d = CTRL_I[5];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      oneshot_q <= 1'b0;
    end else begin
      oneshot_q <= oneshot_d;
    end
  end

  assign oneshot = oneshot_q;
`else
  logic unused_oneshot_bit;

  assign unused_oneshot_bit = CTRL_I[5];
  assign oneshot            = 1'b0;
`endif

  mfp_prescaler u_prescaler (
    .clock  (CLK),
    .reset  (RST),
    .xclk_i (XCLK_I),
    .clear  (presc_clear),
    .select (mode_q[2:0]),
    .tick   (presc_tick)
  );

  // Tick source selection and prescaler clear follow the currently latched mode.
  always_comb begin
    ti_s1_d     = T_I;
    ti_s2_d     = ti_s1_q;
    ti_s3_d     = ti_s2_q;
    mode_kind   = decode_mode(mode_q);
    ti_rise     = ti_s2_q & ~ti_s3_q;
    presc_clear = (mode_kind == MODE_STOPPED) ||
                  (CTRL_WE && (CTRL_I[2:0] != mode_q[2:0]));
    case (mode_kind)
      MODE_DELAY: tick = presc_tick;
      MODE_PULSE: tick = presc_tick && (ti_s2_q == PULSE_POL);
      MODE_EVENT: tick = ti_rise;
      default:    tick = 1'b0;
    endcase
    timeout = tick && (cnt_q == CNT_ONE);
  end

  always_comb begin
    data_d      = data_q;
    cnt_d       = cnt_q;
    dat_o_d     = dat_o_q;
    mode_d      = mode_q;
    t_o_d       = t_o_q;
    t_o_pulse_d = timeout;

    if (DAT_WE) begin
      data_d = DAT_I;
    end

    // A write landing on the reload cycle wins over the stale data register.
    if (mode_kind == MODE_STOPPED) begin
      if (DAT_WE) begin
        cnt_d = DAT_I;
      end
    end else if (timeout) begin
      cnt_d = DAT_WE ? DAT_I : data_q;
    end else if (tick) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    if (timeout) begin
      t_o_d = ~t_o_q;
      if (oneshot) begin
        mode_d = MODE_CODE_STOP;
      end
    end

    if (CTRL_WE) begin
      mode_d = CTRL_I[3:0];
      if (CTRL_I[4]) begin
        t_o_d = 1'b0;
      end
    end

    if (DS) begin
      dat_o_d = cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q      <= '0;
      cnt_q       <= '0;
      dat_o_q     <= '0;
      mode_q      <= MODE_CODE_STOP;
      t_o_q       <= 1'b0;
      t_o_pulse_q <= 1'b0;
      ti_s1_q     <= 1'b0;
      ti_s2_q     <= 1'b0;
      ti_s3_q     <= 1'b0;
    end else begin
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      dat_o_q     <= dat_o_d;
      mode_q      <= mode_d;
      t_o_q       <= t_o_d;
      t_o_pulse_q <= t_o_pulse_d;
      ti_s1_q     <= ti_s1_d;
      ti_s2_q     <= ti_s2_d;
      ti_s3_q     <= ti_s3_d;
    end
  end

  assign DAT_O        = dat_o_q;
  assign CTRL_O       = {oneshot, mode_q};
  assign T_O          = t_o_q;
  assign T_O_PULSE    = t_o_pulse_q;
  assign PULSE_MODE   = (mode_kind == MODE_PULSE);
  assign SET_DATA_OUT = data_q;

endmodule

// File: tb/tb_mfp_timer_n.sv
// Scoreboard bench for mfp_timer_n: a tick-level reference model predicts each timeout,
// a negedge monitor pops predictions whenever T_O_PULSE fires. A 12-bit copy covers wrap.
module tb_mfp_timer_n;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst, xclk, t_i, ds, dat_we, ctrl_we;
  logic [7:0]  dat_i;
  logic [5:0]  ctrl_i;
  logic [7:0]  dat_o, set_data_out;
  logic [4:0]  ctrl_o;
  logic        t_o, t_o_pulse, pulse_mode;
  logic [11:0] dat_i12, dat_o12, set_data_out12;
  logic [4:0]  ctrl_o12;
  logic        t_o12, t_o_pulse12, pulse_mode12;

  assign dat_i12 = {4'h0, dat_i};

  always #5 clk = ~clk;

  mfp_timer_n #(.CNT_W(8), .PULSE_POL(1'b1)) dut (
    .CLK(clk), .RST(rst), .XCLK_I(xclk), .T_I(t_i), .DS(ds),
    .DAT_WE(dat_we), .DAT_I(dat_i), .DAT_O(dat_o),
    .CTRL_WE(ctrl_we), .CTRL_I(ctrl_i), .CTRL_O(ctrl_o),
    .T_O(t_o), .T_O_PULSE(t_o_pulse), .PULSE_MODE(pulse_mode),
    .SET_DATA_OUT(set_data_out)
  );

  mfp_timer_n #(.CNT_W(12), .PULSE_POL(1'b1)) dut12 (
    .CLK(clk), .RST(rst), .XCLK_I(xclk), .T_I(t_i), .DS(ds),
    .DAT_WE(dat_we), .DAT_I(dat_i12), .DAT_O(dat_o12),
    .CTRL_WE(ctrl_we), .CTRL_I(ctrl_i), .CTRL_O(ctrl_o12),
    .T_O(t_o12), .T_O_PULSE(t_o_pulse12), .PULSE_MODE(pulse_mode12),
    .SET_DATA_OUT(set_data_out12)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed in ticks rather than register contents.
  int         m_data;
  int         m_remaining;
  int         m_presc;
  logic [3:0] m_mode;
  logic       m_oneshot;
  logic       m_t_o;
  logic       exp_q[$];
  int         divs[8] = '{0, 4, 10, 16, 50, 64, 100, 200};
  int         pulse12_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit m_running_on_xclk();
    return (m_mode != 4'd0) && (m_mode != 4'd8);
  endfunction

  task automatic model_tick();
    m_remaining--;
    if (m_remaining == 0) begin
      m_t_o = ~m_t_o;
      exp_q.push_back(m_t_o);
      m_remaining = (m_data == 0) ? (2 ** W) : m_data;
      if (m_oneshot) begin
        m_mode  = 4'd0;
        m_presc = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_data      = 0;
    m_remaining = 2 ** W;
    m_presc     = 0;
    m_mode      = 4'd0;
    m_oneshot   = 1'b0;
    m_t_o       = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1; ds = 1'b1;
    dat_we = 1'b1; dat_i = 8'($urandom_range(1, 255));
    ctrl_we = 1'b1; ctrl_i = 6'b011001;
    step();
    check("rst_dat_o", dat_o, 0);
    check("rst_ctrl_o", ctrl_o, 0);
    check("rst_t_o", t_o, 0);
    check("rst_t_o_pulse", t_o_pulse, 0);
    check("rst_pulse_mode", pulse_mode, 0);
    check("rst_set_data_out", set_data_out, 0);
    rst = 1'b0; ds = 1'b0; dat_we = 1'b0; ctrl_we = 1'b0;
    model_reset();
    step();
  endtask

  task automatic write_data(input logic [7:0] v);
    dat_we = 1'b1; dat_i = v;
    step();
    dat_we = 1'b0;
    m_data = v;
    if (m_mode == 4'd0) m_remaining = (v == 0) ? (2 ** W) : v;
    check("set_data_out", set_data_out, v);
  endtask

  task automatic write_ctrl(input logic [5:0] v);
    ctrl_we = 1'b1; ctrl_i = v;
    step();
    ctrl_we = 1'b0;
    if ((v[2:0] != m_mode[2:0]) || (v[3:0] == 4'd0)) m_presc = 0;
    m_mode = v[3:0];
`ifdef MFP_TIMER_ONESHOT_EN
    m_oneshot = v[5];
`else
    m_oneshot = 1'b0;
`endif
    if (v[4]) m_t_o = 1'b0;
    check("ctrl_o", ctrl_o, {m_oneshot, m_mode});
  endtask

  task automatic xclk_edge();
    if (m_running_on_xclk()) begin
      m_presc++;
      if (m_presc == divs[m_mode[2:0]]) begin
        m_presc = 0;
        if (!m_mode[3] || (t_i == 1'b1)) model_tick();
      end
    end
    xclk = 1'b1; step(4);
    xclk = 1'b0; step(4);
  endtask

  task automatic event_edge();
    if (m_mode == 4'd8) model_tick();
    t_i = 1'b1; step(3);
    t_i = 1'b0; step(3);
  endtask

  // Lines DAT_WE up with the cycle in which the synchronised T_I edge is seen.
  task automatic event_with_write(input logic [7:0] v);
    m_data = v;
    if (m_mode == 4'd8) model_tick();
    t_i = 1'b1; step(2);
    dat_we = 1'b1; dat_i = v; step();
    dat_we = 1'b0; step();
    t_i = 1'b0; step(3);
  endtask

  task automatic set_gate(input logic v);
    t_i = v;
    step(4);
  endtask

  task automatic read_counter(input string name);
    ds = 1'b1; step();
    ds = 1'b0;
    check(name, dat_o, 32'(m_remaining % (2 ** W)));
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    check({name, "_t_o"}, t_o, m_t_o);
  endtask

  logic prev_pulse = 1'b0;
  logic exp_t_o;

  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (t_o_pulse) begin
        check("pulse_width", prev_pulse, 0);
        check("pulse_expected", (exp_q.size() == 0) ? 0 : 1, 1);
        if (exp_q.size() != 0) begin
          exp_t_o = exp_q.pop_front();
          check("t_o_at_timeout", t_o, exp_t_o);
        end
      end
      prev_pulse = t_o_pulse;
    end
    if (!rst && t_o_pulse12) pulse12_cnt++;
  end

  initial begin
    int base;
    rst = 1'b1; xclk = 1'b0; t_i = 1'b0; ds = 1'b0;
    dat_we = 1'b0; dat_i = '0; ctrl_we = 1'b0; ctrl_i = '0;
    model_reset();
    step(3);
    apply_reset();

    $display("[TB] delay mode, data 3, divide by 4");
    write_ctrl(6'b000000);
    write_data(8'd3);
    write_ctrl(6'b000001);
    repeat (24) xclk_edge();
    check_drained("delay_drain");
    read_counter("delay_cnt");

    $display("[TB] event mode, data 2, five edges");
    write_ctrl(6'b000000);
    write_data(8'd2);
    write_ctrl(6'b001000);
    repeat (5) event_edge();
    check_drained("event_drain");
    read_counter("event_cnt");
    check("event_pulse_mode", pulse_mode, 0);

    $display("[TB] data write coinciding with reload");
    event_with_write(8'h55);
    check_drained("reload_write_drain");
    read_counter("reload_write_cnt");
    check("reload_write_data", set_data_out, 8'h55);

    $display("[TB] pulse mode gating");
    write_ctrl(6'b000000);
    write_data(8'd5);
    set_gate(1'b0);
    write_ctrl(6'b001001);
    check("pulse_mode_flag", pulse_mode, 1);
    repeat (8) xclk_edge();
    read_counter("pulse_gated_off");
    set_gate(1'b1);
    repeat (8) xclk_edge();
    read_counter("pulse_gated_on");
    set_gate(1'b0);
    check_drained("pulse_drain");

    $display("[TB] one-shot request");
    write_ctrl(6'b000000);
    write_data(8'd1);
    write_ctrl(6'b100001);
    repeat (8) xclk_edge();
    check_drained("oneshot_drain");
    check("oneshot_ctrl_o", ctrl_o, {m_oneshot, m_mode});

    $display("[TB] randomized mode/data sequences");
    for (int it = 0; it < 14; it++) begin
      int kind;
      int n;
      logic [5:0] c;
      kind = $urandom_range(0, 2);
      write_ctrl(6'b000000);
      read_counter("frozen_cnt");
      if ($urandom_range(0, 3) != 0)
        write_data(8'((kind == 1) ? $urandom_range(0, 6) : $urandom_range(1, 6)));
      c = 6'b000000;
      c[4] = ($urandom_range(0, 3) == 0);
      c[5] = ($urandom_range(0, 3) == 0);
      n = $urandom_range(1, 20);
      if (kind == 0) begin
        c[3:0] = 4'($urandom_range(1, 3));
        write_ctrl(c);
        repeat (n * 2) xclk_edge();
      end else if (kind == 1) begin
        c[3:0] = 4'd8;
        write_ctrl(c);
        repeat (n) event_edge();
      end else begin
        c[3:0] = 4'($urandom_range(9, 11));
        write_ctrl(c);
        for (int g = 0; g < 4; g++) begin
          set_gate(1'($urandom_range(0, 1)));
          repeat (n) xclk_edge();
        end
        set_gate(1'b0);
      end
      check_drained("rand_drain");
      read_counter("rand_cnt");
    end

    $display("[TB] reset in the middle of a count");
    write_ctrl(6'b000000);
    write_data(8'd7);
    write_ctrl(6'b000001);
    repeat (10) xclk_edge();
    apply_reset();
    read_counter("post_reset_cnt");

    $display("[TB] 12-bit wrap with data 0");
    write_ctrl(6'b000000);
    write_data(8'd0);
    write_ctrl(6'b001000);
    base = pulse12_cnt;
    repeat (4095) event_edge();
    check("wrap12_before", pulse12_cnt - base, 0);
    event_edge();
    check("wrap12_at", pulse12_cnt - base, 1);
    check("wrap12_t_o", t_o12, 1);
    check_drained("wrap8_drain");

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mfp_timer_n.md
MFP_TIMER_N -- requirements
Module: mfp_timer_n

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the data and down-counter registers (legal 8..16).
REQ-002 SHALL have parameter PULSE_POL, default 1: active level of T_I that gates counting in pulse mode.
REQ-003 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port XCLK_I  input  1  asynchronous timer clock, 2-flop synchronised internally.
REQ-006 SHALL have port T_I  input  1  asynchronous event/gate input, 2-flop synchronised internally.
REQ-007 SHALL have port DS  input  1  bus strobe; read snapshot taken while high.
REQ-008 SHALL have port DAT_WE  input  1  data register write strobe.
REQ-009 SHALL have port DAT_I  input  CNT_W  data register write value.
REQ-010 SHALL have port DAT_O  output  CNT_W  counter snapshot.
REQ-011 SHALL have port CTRL_WE  input  1  control write strobe.
REQ-012 SHALL have port CTRL_I  input  6  [3:0] mode/prescale, [4] force T_O low, [5] one-shot.
REQ-013 SHALL have port CTRL_O  output  5  {one-shot, mode[3:0]}.
REQ-014 SHALL have port T_O  output  1  toggles on every timeout.
REQ-015 SHALL have port T_O_PULSE  output  1  one-cycle timeout strobe.
REQ-016 SHALL have port PULSE_MODE  output  1  high while in pulse mode.
REQ-017 SHALL have port SET_DATA_OUT  output  CNT_W  current data register value.

Function
REQ-018 SHALL decode mode: 0000 stopped; 0001-0111 delay; 1000 event; 1001-1111 pulse.
REQ-019 SHALL, in delay and pulse modes, divide synchronised XCLK_I rising edges by 4,10,16,50,64,100,200 for mode[2:0] = 1..7; each divider wrap is one tick.
REQ-020 SHALL, in pulse mode, count a tick only while synchronised T_I equals PULSE_POL.
REQ-021 SHALL, in event mode, generate one tick per rising edge of synchronised T_I.
REQ-022 SHALL hold the prescaler cleared while stopped, and on any CTRL_WE that changes mode[2:0].
REQ-023 SHALL, on a tick with counter != 1, decrement the counter modulo 2^CNT_W in the next cycle.
REQ-024 SHALL, on a tick with counter == 1, reload the counter from the data register, toggle T_O and drive T_O_PULSE high for exactly that one cycle.
REQ-025 SHALL treat a data value of 0 as 2^CNT_W ticks per timeout.
REQ-026 SHALL, on DAT_WE, update the data register; the counter loads DAT_I directly only while stopped.
REQ-027 SHALL, when DAT_WE coincides with a reload, reload the counter with DAT_I.
REQ-028 SHALL, on CTRL_WE with CTRL_I[4]=1, clear T_O; this takes priority over a simultaneous toggle.
REQ-029 SHALL freeze the counter value when the mode is set to stopped mid-count, and resume from it.
REQ-030 SHALL register DAT_O from the counter on each CLK edge with DS high, and hold it while DS is low.

Reset
REQ-031 SHALL, on RST, clear the data, counter, control, prescaler, DAT_O, T_O, T_O_PULSE and synchroniser flops to 0; PULSE_MODE therefore resets to 0.
REQ-032 SHALL ignore DAT_WE and CTRL_WE in any cycle with RST high.

Configuration
REQ-033 SHALL, with MFP_TIMER_ONESHOT_EN defined, store CTRL_I[5]; when set, a timeout performs REQ-024 and also clears mode to 0000 in the same cycle.
REQ-034 SHALL, without MFP_TIMER_ONESHOT_EN, ignore CTRL_I[5], read CTRL_O[4] as 0, and free-run.

Structure
REQ-035 SHALL take the mode encodings, the mode-decode function and the prescaler divisor table from shared package mfp_timer_pkg.
REQ-036 SHALL implement the XCLK synchroniser plus divider as sub-module mfp_prescaler (inputs: clock, reset, clear, select; output: tick).

Verification
REQ-037 SHALL verify delay mode: CNT_W=8, data=3, mode=0001, XCLK=CLK/8 -> T_O_PULSE every 12 XCLK edges, T_O toggles each time.
REQ-038 SHALL verify event mode: data=2, mode=1000, 5 T_I rising edges -> 2 timeouts, counter reads 1.
REQ-039 SHALL verify pulse mode: PULSE_POL=1, mode=1001, T_I low -> counter frozen; T_I high -> decrements.
REQ-040 SHALL verify wrap: CNT_W=12, data=0, mode=1000 -> timeout after 4096 events.
REQ-041 SHALL verify one-shot (macro on): data=1, CTRL_I=6'b100001 -> single T_O_PULSE, then CTRL_O=5'b10000.
REQ-042 SHALL verify simultaneous events: DAT_WE=0x55 in the reload cycle -> counter=0x55; RST mid-count -> all outputs 0 next cycle.
